// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO deserializer and its neighbours.
// The default width and timeout are also used by the PISO bench,
// so both ends of the serial link agree on word size.
package sipo_pkg;

  localparam int SIPO_DEFAULT_W       = 4;
  localparam int SIPO_DEFAULT_TIMEOUT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_t;

endpackage

// File: rtl/sipo_gap_timer.sv
// Idle-gap timer for the deserializer.
// Counts consecutive idle cycles while a word is in progress. It raises
// expire combinationally in the cycle that holds the TIMEOUT-th idle
// sample, so the parent can abort on that same edge and err_o shows up
// in the following cycle. TIMEOUT=0 disables the timer.
import sipo_pkg::*;

module sipo_gap_timer #(
  parameter int TIMEOUT = SIPO_DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam int GW = $clog2(TIMEOUT + 1);
      localparam logic [GW-1:0] GAP_MAX  = GW'(TIMEOUT);
      localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);

      logic [GW-1:0] r_gap;

      // Saturating idle counter; clear wins over count
      always_ff @(posedge clk) begin
        if (reset || clr) begin
          r_gap <= '0;
        end else if (en && (r_gap != GAP_MAX)) begin
          r_gap <= r_gap + GW'(1);
        end
      end

      assign expire = en && (r_gap == GAP_LAST);
    end
  endgenerate

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver, downstream partner of the PISO.
// Gathers one qualified bit per cycle into a W-bit word, publishes each
// finished word with a one-cycle valid pulse, and drops a stalled
// partial word (with a one-cycle err pulse) after TIMEOUT idle cycles.
import sipo_pkg::*;

module sipo_deserializer #(
  parameter int W         = SIPO_DEFAULT_W,
  parameter int LSB_FIRST = 1,
  parameter int TIMEOUT   = SIPO_DEFAULT_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_i,
  input  logic         serial_i,
  output logic [W-1:0] parallel_o,
  output logic         valid_o,
  output logic         empty_o,
  output logic         err_o
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  sipo_state_t   r_state;
  sipo_state_t   w_nextState;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_shift;
  logic [W-1:0]  r_parallel;
  logic          r_valid;
  logic          r_empty;
  logic          r_err;

  logic [CW-1:0] w_idx;
  logic [W-1:0]  w_nextShift;
  logic          w_store;
  logic          w_last;
  logic          w_gapEn;
  logic          w_gapClr;
  logic          w_expire;

  sipo_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gapTimer (
    .clk    (clk),
    .reset  (reset),
    .en     (w_gapEn),
    .clr    (w_gapClr),
    .expire (w_expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: a bit starts a word, the last bit or a timeout ends it
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (valid_i) w_nextState = SHIFT;
      SHIFT:   if (w_last || w_expire) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // FSM decode: when to store, when the word completes, gap timer control
  always_comb begin
    w_store  = valid_i;
    w_last   = (r_state == SHIFT) && valid_i && (r_count == LAST_IDX);
    w_gapEn  = (r_state == SHIFT) && !valid_i;
    w_gapClr = valid_i || (r_state == IDLE);
  end

  // Place the incoming bit at its word position according to bit order
  always_comb begin
    w_idx = (LSB_FIRST != 0) ? r_count : (LAST_IDX - r_count);
    w_nextShift = r_shift;
    w_nextShift[w_idx] = serial_i;
  end

  // Shift register, bit counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift    <= '0;
      r_count    <= '0;
      r_parallel <= '0;
      r_valid    <= 1'b0;
      r_empty    <= 1'b1;
      r_err      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (w_store) begin
        r_shift <= w_nextShift;
        if (w_last) begin
          r_count    <= '0;
          r_parallel <= w_nextShift;
          r_valid    <= 1'b1;
          r_empty    <= 1'b1;
        end else begin
          r_count <= r_count + CW'(1);
          r_empty <= 1'b0;
        end
      end else if (w_expire) begin
        r_count <= '0;
        r_err   <= 1'b1;
        r_empty <= 1'b1;
      end
    end
  end

  assign parallel_o = r_parallel;
  assign valid_o    = r_valid;
  assign empty_o    = r_empty;
  assign err_o      = r_err;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer with W=4, LSB_FIRST=1, TIMEOUT=8.
// Inputs change 1 time unit after each rising edge and outputs are
// checked at that same point, i.e. they show what the previous edge did.
module tb_sipo_deserializer;

  logic       clk;
  logic       reset;
  logic       valid_i;
  logic       serial_i;
  logic [3:0] parallel_o;
  logic       valid_o;
  logic       empty_o;
  logic       err_o;

  int errors;
  int checks;

  logic [3:0] word;

  sipo_deserializer #(
    .W         (4),
    .LSB_FIRST (1),
    .TIMEOUT   (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (valid_i),
    .serial_i   (serial_i),
    .parallel_o (parallel_o),
    .valid_o    (valid_o),
    .empty_o    (empty_o),
    .err_o      (err_o)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of input, then move just past the sampling edge
  task automatic applyStimulus(input logic v, input logic s);
    valid_i  = v;
    serial_i = s;
    @(posedge clk);
    #1;
  endtask

  // Compare every output against the hand-computed expectation
  task automatic checkOutput(input string tag, input logic [3:0] expP,
                             input logic expV, input logic expE, input logic expR);
    checks++;
    assert (parallel_o === expP) else begin
      errors++;
      $error("[TB] FAIL %s parallel_o: got %h expected %h", tag, parallel_o, expP);
    end
    checks++;
    assert (valid_o === expV) else begin
      errors++;
      $error("[TB] FAIL %s valid_o: got %b expected %b", tag, valid_o, expV);
    end
    checks++;
    assert (empty_o === expE) else begin
      errors++;
      $error("[TB] FAIL %s empty_o: got %b expected %b", tag, empty_o, expE);
    end
    checks++;
    assert (err_o === expR) else begin
      errors++;
      $error("[TB] FAIL %s err_o: got %b expected %b", tag, err_o, expR);
    end
  endtask

  // Directed sequence
  initial begin
    errors   = 0;
    checks   = 0;
    reset    = 1'b1;
    valid_i  = 1'b0;
    serial_i = 1'b0;
    @(posedge clk);
    #1;

    // Reset held for two cycles
    applyStimulus(1'b0, 1'b0);
    checkOutput("reset1", 4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("reset2", 4'h0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;

    // Twenty idle cycles, serial_i toggling but not qualified
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'(i % 2));
      checkOutput("idle", 4'h0, 1'b0, 1'b1, 1'b0);
    end

    // Bits 1,0,1,1 -> 4'hD
    word = 4'hD;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, word[k]);
      checkOutput("wordD_partial", 4'h0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, word[3]);
    checkOutput("wordD_done", 4'hD, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("wordD_after", 4'hD, 1'b0, 1'b1, 1'b0);

    // Back-to-back 4'hA then 4'h5
    word = 4'hA;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, word[k]);
      checkOutput("wordA_partial", 4'hD, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, word[3]);
    checkOutput("wordA_done", 4'hA, 1'b1, 1'b1, 1'b0);
    word = 4'h5;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, word[k]);
      checkOutput("word5_partial", 4'hA, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, word[3]);
    checkOutput("word5_done", 4'h5, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("word5_after", 4'h5, 1'b0, 1'b1, 1'b0);

    // 4'h6 with three idle cycles between bits
    word = 4'h6;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, word[k]);
      checkOutput("word6_bit", 4'h5, 1'b0, 1'b0, 1'b0);
      for (int g = 0; g < 3; g++) begin
        applyStimulus(1'b0, 1'b1);
        checkOutput("word6_gap", 4'h5, 1'b0, 1'b0, 1'b0);
      end
    end
    applyStimulus(1'b1, word[3]);
    checkOutput("word6_done", 4'h6, 1'b1, 1'b1, 1'b0);

    // Two bits then eight idle cycles -> abort
    applyStimulus(1'b1, 1'b1);
    checkOutput("abort_bit0", 4'h6, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("abort_bit1", 4'h6, 1'b0, 1'b0, 1'b0);
    for (int g = 0; g < 7; g++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("abort_gap", 4'h6, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("abort_err", 4'h6, 1'b0, 1'b1, 1'b1);

    // Fresh word 1,1,0,0 -> 4'h3
    word = 4'h3;
    applyStimulus(1'b1, word[0]);
    checkOutput("word3_bit0", 4'h6, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < 3; k++) begin
      applyStimulus(1'b1, word[k]);
      checkOutput("word3_partial", 4'h6, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, word[3]);
    checkOutput("word3_done", 4'h3, 1'b1, 1'b1, 1'b0);

    // Two bits, seven idle cycles (one short of timeout), finish as 4'h6
    word = 4'h6;
    applyStimulus(1'b1, word[0]);
    checkOutput("gap7_bit0", 4'h3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, word[1]);
    checkOutput("gap7_bit1", 4'h3, 1'b0, 1'b0, 1'b0);
    for (int g = 0; g < 7; g++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("gap7_idle", 4'h3, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, word[2]);
    checkOutput("gap7_bit2", 4'h3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, word[3]);
    checkOutput("gap7_done", 4'h6, 1'b1, 1'b1, 1'b0);

    // Three bits of 4'hF, then reset mid-word
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput("wordF_partial", 4'h6, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("midreset", 4'h0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;

    // Bits of 4'h9 after reset
    word = 4'h9;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, word[k]);
      checkOutput("word9_partial", 4'h0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, word[3]);
    checkOutput("word9_done", 4'h9, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("word9_after", 4'h9, 1'b0, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
